// File: rtl/cordic_gain_comp.sv
// Multi-channel gain-compensation scaler for CORDIC x/y outputs.
// Each packed signed channel is multiplied by a runtime-loadable coefficient.
// The product is optionally rounded, saturated symmetrically and sent through
// a LATENCY-deep stallable pipeline together with its side-band code.
module cordic_gain_comp #(
    parameter int WIDTH      = 16,
    parameter int FRAC_BITS  = 12,
    parameter int COEF_WIDTH = 16,
    parameter int NCH        = 2,
    parameter int LATENCY    = 4,
    parameter int CODE_WIDTH = 8,
    parameter int GAIN_RESET = 2488
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NCH*WIDTH-1:0]    in_data,
    input  logic [CODE_WIDTH-1:0]   in_code,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NCH*WIDTH-1:0]    out_data,
    output logic [CODE_WIDTH-1:0]   out_code,
    output logic [NCH-1:0]          out_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic [COEF_WIDTH-1:0]   gain_in,
    input  logic                    gain_load,
    input  logic                    round_en,
    output logic                    sat_sticky,
    input  logic                    sat_clear
);

    // Full-precision product width; a WIDTH x COEF_WIDTH signed product
    // plus the rounding constant always fits in this many bits.
    localparam int PW = WIDTH + COEF_WIDTH;

    localparam logic signed [PW-1:0] MAX_V   = {{(COEF_WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V   = {{(COEF_WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] ROUND_C = PW'(1) << (FRAC_BITS-1);

    logic signed [COEF_WIDTH-1:0] coef_reg;
    logic                         sat_sticky_reg;
    logic                         stall;
    logic                         advance;

    logic [NCH*WIDTH-1:0]         stage_in_data;
    logic [NCH-1:0]               stage_in_sat;

    logic                         valid_reg [LATENCY];
    logic [NCH*WIDTH-1:0]         data_reg  [LATENCY];
    logic [CODE_WIDTH-1:0]        code_reg  [LATENCY];
    logic [NCH-1:0]               sat_reg   [LATENCY];

    // The whole pipeline freezes only when the last stage holds data that
    // downstream refuses; otherwise every stage moves forward one step.
    assign stall    = valid_reg[LATENCY-1] & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    // Coefficient register: a load takes effect at the edge, so a sample
    // accepted in the same cycle still sees the previous value.
    always_ff @(posedge clock) begin
        if (reset) begin
            coef_reg <= COEF_WIDTH'(GAIN_RESET);
        end else if (gain_load) begin
            coef_reg <= gain_in;
        end
    end

    // Per-channel multiply, optional round-half-up, floor shift, clamp.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic signed [PW-1:0] samp_ext;
            logic signed [PW-1:0] coef_ext;
            logic signed [PW-1:0] prod;
            logic signed [PW-1:0] prod_rnd;
            logic signed [PW-1:0] shifted;
            logic                 sat_hi;
            logic                 sat_lo;

            assign samp_ext = {{COEF_WIDTH{in_data[gi*WIDTH+WIDTH-1]}}, in_data[gi*WIDTH +: WIDTH]};
            assign coef_ext = {{WIDTH{coef_reg[COEF_WIDTH-1]}}, coef_reg};
            assign prod     = samp_ext * coef_ext;
            assign prod_rnd = round_en ? (prod + ROUND_C) : prod;
            assign shifted  = prod_rnd >>> FRAC_BITS;
            assign sat_hi   = (shifted > MAX_V);
            assign sat_lo   = (shifted < MIN_V);

            assign stage_in_data[gi*WIDTH +: WIDTH] = sat_hi ? MAX_V[WIDTH-1:0] :
                                                      sat_lo ? MIN_V[WIDTH-1:0] :
                                                               shifted[WIDTH-1:0];
            assign stage_in_sat[gi] = sat_hi | sat_lo;
        end
    endgenerate

    // Stage 0 captures the freshly scaled sample, or a bubble when no input is offered.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg[0] <= 1'b0;
            data_reg[0]  <= '0;
            code_reg[0]  <= '0;
            sat_reg[0]   <= '0;
        end else if (advance) begin
            valid_reg[0] <= in_valid;
            data_reg[0]  <= stage_in_data;
            code_reg[0]  <= in_code;
            sat_reg[0]   <= stage_in_sat;
        end
    end

    // Remaining stages shift data, code and sat flags in lockstep.
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
            // Move stage gi-1 into stage gi whenever the pipeline advances.
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                    code_reg[gi]  <= '0;
                    sat_reg[gi]   <= '0;
                end else if (advance) begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    data_reg[gi]  <= data_reg[gi-1];
                    code_reg[gi]  <= code_reg[gi-1];
                    sat_reg[gi]   <= sat_reg[gi-1];
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[LATENCY-1];
    assign out_data  = data_reg[LATENCY-1];
    assign out_code  = code_reg[LATENCY-1];
    assign out_sat   = sat_reg[LATENCY-1];

    // Sticky saturation flag: set by a saturated sample leaving the block; set beats clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            sat_sticky_reg <= 1'b0;
        end else if (out_valid && out_ready && (|out_sat)) begin
            sat_sticky_reg <= 1'b1;
        end else if (sat_clear) begin
            sat_sticky_reg <= 1'b0;
        end
    end

    assign sat_sticky = sat_sticky_reg;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp: directed vector table, hand-written
// stall / coefficient / reset sequences, and a randomized phase checked by a
// free-running scoreboard monitor.
module tb_cordic_gain_comp;

    localparam int W     = 16;
    localparam int FRAC  = 12;
    localparam int CW    = 16;
    localparam int NCH   = 2;
    localparam int LAT   = 4;
    localparam int CODEW = 8;
    localparam int GRST  = 2488;

    logic                 clock;
    logic                 reset;
    logic [NCH*W-1:0]     in_data;
    logic [CODEW-1:0]     in_code;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*W-1:0]     out_data;
    logic [CODEW-1:0]     out_code;
    logic [NCH-1:0]       out_sat;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        gain_in;
    logic                 gain_load;
    logic                 round_en;
    logic                 sat_sticky;
    logic                 sat_clear;

    cordic_gain_comp #(
        .WIDTH(W), .FRAC_BITS(FRAC), .COEF_WIDTH(CW), .NCH(NCH),
        .LATENCY(LAT), .CODE_WIDTH(CODEW), .GAIN_RESET(GRST)
    ) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_code(out_code), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .gain_in(gain_in), .gain_load(gain_load), .round_en(round_en),
        .sat_sticky(sat_sticky), .sat_clear(sat_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cnt_cmp  = 0;
    int cnt_fail = 0;
    int n_xfer   = 0;

    typedef struct {
        logic [NCH*W-1:0] data;
        logic [CODEW-1:0] code;
        logic [NCH-1:0]   sat;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        cnt_cmp++;
        if (act !== req) begin
            cnt_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: exact integer product, optional +half, floor division by 2^FRAC, clamp.
    function automatic exp_t model(input logic [NCH*W-1:0] d, input int coef,
                                   input bit rnd, input logic [CODEW-1:0] code);
        exp_t   e;
        longint p;
        longint r;
        longint maxv;
        longint minv;
        logic signed [W-1:0] s;
        maxv   = (longint'(1) <<< (W-1)) - 1;
        minv   = -(longint'(1) <<< (W-1));
        e.code = code;
        e.data = '0;
        e.sat  = '0;
        for (int c = 0; c < NCH; c++) begin
            s = d[c*W +: W];
            p = longint'(s) * longint'(coef);
            if (rnd) p = p + (longint'(1) <<< (FRAC-1));
            r = p >>> FRAC;
            if (r > maxv) begin r = maxv; e.sat[c] = 1'b1; end
            if (r < minv) begin r = minv; e.sat[c] = 1'b1; end
            e.data[c*W +: W] = W'(r);
        end
        return e;
    endfunction

    // Scoreboard monitor: samples at the falling edge, checks transfers,
    // output stability under stall and the sticky flag every cycle.
    initial begin
        exp_t             e;
        int               model_coef;
        bit               model_sticky;
        bit               prev_stall;
        bit               xfer;
        bit               acc;
        logic [NCH*W-1:0] prev_data;
        logic [CODEW-1:0] prev_code;
        logic [NCH-1:0]   prev_sat;
        model_coef   = GRST;
        model_sticky = 1'b0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        prev_code    = '0;
        prev_sat     = '0;
        @(posedge clock);
        forever begin
            @(negedge clock);
            if (prev_stall) begin
                chk("hold_stable", {out_valid, out_sat, out_code, out_data},
                    {1'b1, prev_sat, prev_code, prev_data});
            end
            chk("sat_sticky", 64'(sat_sticky), 64'(model_sticky));
            xfer = out_valid && out_ready && !reset;
            acc  = in_valid && in_ready && !reset;
            e.sat = '0;
            if (xfer) begin
                n_xfer++;
                $display("xfer %0d: data=%h code=%h sat=%b", n_xfer, out_data, out_code, out_sat);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard", {out_sat, out_code, out_data}, {e.sat, e.code, e.data});
                end
            end
            if (acc) exp_q.push_back(model(in_data, model_coef, round_en, in_code));
            if (reset) begin
                exp_q.delete();
                model_coef   = GRST;
                model_sticky = 1'b0;
            end else begin
                if (gain_load) model_coef = int'($signed(gain_in));
                if (xfer && (|e.sat)) model_sticky = 1'b1;
                else if (sat_clear)   model_sticky = 1'b0;
            end
            prev_stall = out_valid && !out_ready && !reset;
            prev_data  = out_data;
            prev_code  = out_code;
            prev_sat   = out_sat;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit         load;
        int         gain;
        bit         rnd;
        int         ch0;
        int         ch1;
        logic [7:0] code;
        int         e0;
        int         e1;
        logic [1:0] esat;
    } vec_t;

    vec_t vecs [9];

    // Wait (bounded) for out_valid with out_ready held high; returns ticks waited.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int               n;
        int               got;
        int               idx;
        int               c;
        bit               sticky_exp;
        logic [W-1:0]     e0;
        logic [W-1:0]     e1;
        logic [NCH*W-1:0] held;

        vecs[0] = '{1'b0, 0,      1'b1,  4096,      3, 8'h5A,  2488,      2, 2'b00};
        vecs[1] = '{1'b0, 0,      1'b0,     3,     -1, 8'h11,     1,     -1, 2'b00};
        vecs[2] = '{1'b0, 0,      1'b1,     3,     -1, 8'h12,     2,     -1, 2'b00};
        vecs[3] = '{1'b0, 0,      1'b0,  4096,  -4096, 8'h13,  2488,  -2488, 2'b00};
        vecs[4] = '{1'b0, 0,      1'b1,     0,      1, 8'h14,     0,      1, 2'b00};
        vecs[5] = '{1'b1, 16384,  1'b1, 10000, -10000, 8'h15, 32767, -32768, 2'b11};
        vecs[6] = '{1'b1, 4096,   1'b0, 32767, -32768, 8'h16, 32767, -32768, 2'b00};
        vecs[7] = '{1'b1, 4097,   1'b0, 32767, -32768, 8'h17, 32767, -32768, 2'b11};
        vecs[8] = '{1'b1, -4096,  1'b0, -32768,     5, 8'h18, 32767,     -5, 2'b01};

        reset     = 1'b1;
        in_data   = '0;
        in_code   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        gain_in   = '0;
        gain_load = 1'b0;
        round_en  = 1'b0;
        sat_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_outputs", {out_sat, out_code, out_data}, 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_sticky", 64'(sat_sticky), 64'(0));

        // Vector table: one sample at a time, latency and value checked
        sticky_exp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].load) begin
                gain_in   = CW'(vecs[i].gain);
                gain_load = 1'b1;
                tick();
                gain_load = 1'b0;
            end
            in_data  = {W'(vecs[i].ch1), W'(vecs[i].ch0)};
            in_code  = vecs[i].code;
            round_en = vecs[i].rnd;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            wait_out(n);
            chk($sformatf("vec%0d_latency", i), 64'(n + 1), 64'(LAT));
            e0 = W'(vecs[i].e0);
            e1 = W'(vecs[i].e1);
            chk($sformatf("vec%0d_data", i), 64'(out_data), {32'd0, e1, e0});
            chk($sformatf("vec%0d_code_sat", i), {out_sat, out_code}, {vecs[i].esat, vecs[i].code});
            tick();
            sticky_exp = sticky_exp | (|vecs[i].esat);
            chk($sformatf("vec%0d_sticky", i), 64'(sat_sticky), 64'(sticky_exp));
        end

        // Clear the sticky flag
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("sticky_cleared", 64'(sat_sticky), 64'(0));

        // Back-to-back stream 1..8 with a 3-cycle downstream stall
        gain_in   = CW'(4096);
        gain_load = 1'b1;
        round_en  = 1'b0;
        tick();
        gain_load = 1'b0;
        idx = 0;
        got = 0;
        c   = 0;
        held = '0;
        while (got < 8 && c < 60) begin
            out_ready = !(c >= 6 && c < 9);
            if (idx < 8) begin
                in_valid = 1'b1;
                in_data  = {W'(-(idx + 1)), W'(idx + 1)};
                in_code  = CODEW'(idx + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 6 && c < 9) begin
                chk($sformatf("stall_in_ready_c%0d", c), 64'(in_ready), 64'(0));
                if (c == 6) held = out_data;
                else chk($sformatf("stall_stable_c%0d", c), 64'(out_data), 64'(held));
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stream_%0d", got + 1), {out_code, out_data},
                    {CODEW'(got + 1), W'(-(got + 1)), W'(got + 1)});
                got++;
            end
            if (in_valid && in_ready) idx++;
            tick();
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 64'(got), 64'(8));

        // Gain load in the same cycle as sample A; sample B sees the new gain
        gain_in   = CW'(8192);
        gain_load = 1'b1;
        in_valid  = 1'b1;
        in_data   = {W'(100), W'(100)};
        in_code   = 8'hA1;
        tick();
        gain_load = 1'b0;
        in_code   = 8'hB2;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        chk("gain_old_A", {out_code, out_data}, {8'hA1, W'(100), W'(100)});
        tick();
        chk("gain_new_B", {out_valid, out_code, out_data}, {1'b1, 8'hB2, W'(200), W'(200)});
        tick();

        // Reset with three samples in flight
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = {W'(k + 7), W'(k + 7)};
            in_code  = CODEW'(8'hC0 + k);
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        chk("midreset_out_valid", 64'(out_valid), 64'(0));
        chk("midreset_outputs", {out_sat, out_code, out_data}, 64'(0));
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) n++;
        end
        chk("no_stale_outputs", 64'(n), 64'(0));
        in_valid = 1'b1;
        round_en = 1'b0;
        in_data  = {W'(0), W'(4096)};
        in_code  = 8'h77;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        chk("coef_after_reset", {out_code, out_data}, {8'h77, W'(0), W'(2488)});
        tick();

        // Randomized traffic against the scoreboard
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       in_data = {W'(32767), W'(-32768)};
                1:       in_data = {W'($urandom_range(0, 7)), W'(-$urandom_range(0, 7))};
                default: in_data = NCH*W'($urandom);
            endcase
            in_code   = CODEW'($urandom);
            round_en  = $urandom_range(0, 1) != 0;
            out_ready = ($urandom_range(0, 3) != 0);
            gain_load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       gain_in = CW'(2488);
                1:       gain_in = CW'(4096);
                2:       gain_in = CW'(-4096);
                default: gain_in = CW'($urandom);
            endcase
            sat_clear = ($urandom_range(0, 7) == 0);
            tick();
        end
        in_valid  = 1'b0;
        gain_load = 1'b0;
        sat_clear = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
        $finish;
    end

endmodule

// File: doc/cordic_gain_comp.md
Name: cordic_gain_comp

Overview:
- Multi-channel CORDIC gain-compensation scaler with a valid/ready stream interface.
- Multiplies each packed signed channel by a runtime-loadable signed gain coefficient. Default coefficient is 1/K ≈ 0.60725.
- Applies optional rounding and symmetric saturation, then passes data through a LATENCY-deep stallable pipeline with a side-band code.
- Sits between CORDIC rotator outputs (x/y pairs) and downstream consumers that may apply backpressure.

Parameters:
- WIDTH, 16: per-channel sample width, signed, FRAC_BITS fractional bits.
- FRAC_BITS, 12: fractional bits of both sample and coefficient.
- COEF_WIDTH, 16: signed gain coefficient width.
- NCH, 2: number of channels packed in the data buses.
- LATENCY, 4: pipeline depth in accepted-advance cycles; must be ≥1.
- CODE_WIDTH, 8: side-band code width, passed through unmodified.
- GAIN_RESET, 2488: coefficient value after reset (1/K · 2^12).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- in_code  in  CODE_WIDTH  side-band code.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- out_data  out  NCH*WIDTH  scaled samples, same packing as in_data.
- out_code  out  CODE_WIDTH  code delayed with its sample.
- out_sat  out  NCH  per-channel flag: this sample was saturated.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- gain_in  in  COEF_WIDTH  new coefficient, signed.
- gain_load  in  1  load gain_in into the coefficient register.
- round_en  in  1  1 = round half toward +inf; 0 = truncate (floor).
- sat_sticky  out  1  set on any saturation.
- sat_clear  in  1  clears sat_sticky.

Behaviour:
- Reset (synchronous, any time, including mid-stream):
  - all pipeline valid bits = 0, data/code/sat stages = 0.
  - coefficient = GAIN_RESET, sat_sticky = 0.
  - out_valid = 0, out_data = 0, out_code = 0, out_sat = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - In-flight samples are discarded.
- Handshake:
  - stall = out_valid & !out_ready.
  - in_ready = !stall (combinational).
  - The pipeline advances every cycle stall = 0.
  - Accept when in_valid & in_ready. When in_valid = 0, a bubble (valid = 0) enters stage 0.
  - When stall = 1, all stages hold.
  - Transfer when out_valid & out_ready.
- Latency: a sample accepted in cycle t appears on out_* at t+LATENCY, given no stalls. Each stall cycle adds one cycle.
- Arithmetic, per channel, computed before stage 0:
  - p = in_data_c * coef, signed, WIDTH+COEF_WIDTH bits.
  - If round_en: p += 2^(FRAC_BITS-1).
  - r = p >>> FRAC_BITS (arithmetic shift).
  - If r > 2^(WIDTH-1)-1: clamp to the max, sat_c = 1.
  - If r < -2^(WIDTH-1): clamp to the min, sat_c = 1.
  - round_en is sampled at acceptance.
- Coefficient:
  - gain_load writes coef at the clock edge.
  - Samples accepted in the same cycle use the old coef. Samples accepted later use the new one.
  - Loading is allowed during a stall and has no effect on samples already in flight.
- sat_sticky:
  - Set when a sample with any sat bit set is transferred out.
  - sat_clear clears it.
  - Simultaneous set and clear: set wins.
- Code and sat bits travel in lockstep with the data.
- Output buses are held stable while stalled.

Test Plan:
- Reset, round_en = 1, ch0 = 4096, ch1 = 3, code 0x5A, out_ready = 1 → after LATENCY cycles: ch0 = 2488, ch1 = 2, code 0x5A, out_sat = 0.
- round_en = 0, ch0 = 3, ch1 = -1 → ch0 = 1, ch1 = -1. With round_en = 1 → ch0 = 2, ch1 = -1.
- gain_load gain_in = 16384, then ch0 = 10000, ch1 = -10000 → 32767, -32768, out_sat = 2'b11, sat_sticky = 1. Then sat_clear → sat_sticky = 0.
- Stream 8 back-to-back samples 1..8 (gain 4096). Hold out_ready = 0 for 3 cycles mid-stream → in_ready = 0 during the stall. Output sequence is 1..8 with no loss or duplication, and out_data is stable while stalled.
- gain_load in the same cycle as acceptance of sample A, then sample B → A uses the old gain, B uses the new one.
- Assert reset with 3 samples in flight → out_valid = 0 the next cycle. After reset, coef = 2488 and no stale samples emerge.
